gcd_controller: RTL and testbench

//  FSM that sequences the shared subtract/shift datapath to compute GCD(a,b) with
//  the binary (Stein) algorithm. Strips common factors of two, reduces operands with
//  2's-complement subtraction (x + ~y + 1) and single-bit right shifts, then restores
//  the factor 2^k with one multi-bit left shift. Sits between the operand source and
//  the result consumer; one computation in flight at a time.

---
 rtl/gcd_controller_if.sv | 33 +++
 rtl/gcd_controller.sv | 123 ++++++++++++
 tb/tb_gcd_controller.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_controller_if.sv
// Request/response bundle between the operand source and the GCD engine.
// Source drives start/a/b and observes busy/done/gcd.
// Ports: start, a, b (source -> engine); busy, done, gcd (engine -> source).
interface gcd_controller_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] gcd;

    // Operand source / result consumer side.
    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  gcd
    );

    // GCD engine side.
    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output gcd
    );
endinterface

// File: rtl/gcd_controller.sv
// Purpose: binary (Stein) GCD engine on one shared subtract/shift datapath.
// Latency: done 2 cycles after accept for a zero operand, at most 4*WIDTH+4 otherwise.
// Backpressure: one job in flight; start is ignored unless idle (busy low).
// Ports: clk, rst_n (async active-low); bus.start/a/b request, bus.busy/done/gcd result.
//        gcd holds its value until it is rewritten by the next computation.
module gcd_controller #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    gcd_controller_if.slave bus
);
    localparam int KW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ODDA,
        REDUCE,
        SCALE,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [KW-1:0]    k;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] gcd_q;

    // Single subtractor ra + ~rb + 1. Its carry-out is the "no borrow" flag,
    // i.e. ra >= rb, and doubles as the comparator for the reduce step.
    logic [WIDTH:0]   sub;
    logic             ra_ge_rb;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] neg_diff;

    assign sub      = {1'b0, ra} + {1'b0, ~rb} + {{WIDTH{1'b0}}, 1'b1};
    assign ra_ge_rb = sub[WIDTH];
    assign diff     = sub[WIDTH-1:0];
    // When ra < rb the wrapped difference is -(rb - ra); negate it back.
    assign neg_diff = ~diff + {{(WIDTH-1){1'b0}}, 1'b1};

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.gcd  = gcd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            k      <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            gcd_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        ra     <= bus.a;
                        rb     <= bus.b;
                        k      <= '0;
                        busy_q <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (ra == '0 || rb == '0) begin
                        gcd_q  <= ra | rb;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (!ra[0] && !rb[0]) begin
                        // Common factor of two: remember it in k.
                        ra <= ra >> 1;
                        rb <= rb >> 1;
                        k  <= k + KW'(1);
                    end else begin
                        state <= ODDA;
                    end
                end
                ODDA: begin
                    if (!ra[0]) begin
                        ra <= ra >> 1;
                    end else begin
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    // ra stays odd here, so the difference of two odds is even
                    // and the following cycles shift it down.
                    if (rb == '0) begin
                        state <= SCALE;
                    end else if (!rb[0]) begin
                        rb <= rb >> 1;
                    end else if (ra_ge_rb) begin
                        // Equal operands land here too; the outcome (ra kept,
                        // rb cleared) is the same as the rb - ra branch.
                        ra <= rb;
                        rb <= diff;
                    end else begin
                        rb <= neg_diff;
                    end
                end
                SCALE: begin
                    gcd_q  <= ra << k;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_controller.sv
// Self-checking bench for gcd_controller: directed cases plus random pairs
// compared against a Euclid-based reference model.
// Ports driven through the gcd_controller_if instance; clk period 10.
module tb_gcd_controller;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    gcd_controller_if #(.WIDTH(W)) bus ();

    gcd_controller #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: Euclid by remainder, gcd(x,0)=x, gcd(0,0)=0.
    function automatic int ref_gcd(input int x, input int y);
        int p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Number of common factors of two (0 if either operand is zero).
    function automatic int ref_k(input int x, input int y);
        int n;
        n = 0;
        if (x == 0 || y == 0) return 0;
        while ((x % 2 == 0) && (y % 2 == 0)) begin
            x = x / 2;
            y = y / 2;
            n++;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle, then scramble the operands so that
    // only the accepting edge can have sampled them.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    // Full transaction with checks; returns latency (cycles after accept at
    // which done is seen) and the result.
    task automatic run_gcd(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output logic [W-1:0] res);
        int found;
        int busy_bad;
        logic done_after;
        logic busy_after;
        logic [W-1:0] gcd_after;
        found    = 0;
        busy_bad = 0;
        lat      = 0;
        res      = '0;
        launch(a, b);
        for (int c = 1; c <= 60 && found == 0; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.done === 1'b1) begin
                found = 1;
                lat   = c;
                res   = bus.gcd;
            end else begin
                @(posedge clk);
            end
        end
        chk({tag, "_done_seen"}, found, 1);
        chk({tag, "_gcd"}, res, ref_gcd(a, b));
        chk({tag, "_busy_during"}, busy_bad, 0);
        checks++;
        assert (found == 1 && lat <= 4 * W + 4) else begin
            failures++;
            $error("FAIL %s_latency observed=%0d expected<=%0d", tag, lat, 4 * W + 4);
        end
        @(negedge clk);
        done_after = bus.done;
        busy_after = bus.busy;
        gcd_after  = bus.gcd;
        chk({tag, "_done_width"}, done_after, 1'b0);
        chk({tag, "_busy_after"}, busy_after, 1'b0);
        chk({tag, "_gcd_hold"}, gcd_after, ref_gcd(a, b));
    endtask

    initial begin
        int lat;
        logic [W-1:0] res;
        int cnt;
        int first;
        logic busy_after;
        logic [W-1:0] ra_v;
        logic [W-1:0] rb_v;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state.
        #12;
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_done", bus.done, 1'b0);
        chk("reset_gcd", bus.gcd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", bus.busy, 1'b0);

        // 48,18 -> 6 with one common factor of two.
        run_gcd("t48_18", 8'd48, 8'd18, lat, res);
        chk("t48_18_k", dut.k, ref_k(48, 18));

        // Zero operands finish two cycles after accept.
        run_gcd("t0_35", 8'd0, 8'd35, lat, res);
        chk("t0_35_lat", lat, 2);
        run_gcd("t0_0", 8'd0, 8'd0, lat, res);
        chk("t0_0_lat", lat, 2);
        run_gcd("t77_0", 8'd77, 8'd0, lat, res);
        chk("t77_0_lat", lat, 2);

        // Boundary values.
        run_gcd("t128_64", 8'd128, 8'd64, lat, res);
        chk("t128_64_k", dut.k, ref_k(128, 64));
        run_gcd("t255_255", 8'd255, 8'd255, lat, res);
        run_gcd("t1_254", 8'd1, 8'd254, lat, res);

        // start while busy, and held through the done cycle, is ignored.
        launch(8'd200, 8'd150);
        cnt        = 0;
        first      = 0;
        busy_after = 1'b1;
        res        = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                cnt++;
                if (first == 0) begin
                    first = c;
                    res   = bus.gcd;
                end
            end
            if (first != 0 && c == first + 1) begin
                busy_after = bus.busy;
                bus.start  = 1'b0;
            end else if (c == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'd9;
                bus.b     = 8'd3;
            end
        end
        bus.start = 1'b0;
        chk("busy_ignore_gcd", res, ref_gcd(200, 150));
        chk("busy_ignore_pulses", cnt, 1);
        chk("done_cycle_ignore", busy_after, 1'b0);
        run_gcd("t9_3", 8'd9, 8'd3, lat, res);

        // Reset while reducing aborts silently.
        launch(8'd180, 8'd84);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_gcd", bus.gcd, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        run_gcd("t180_84", 8'd180, 8'd84, lat, res);

        // Random pairs, with some operands forced to zero or powers of two.
        for (int i = 0; i < 1200; i++) begin
            ra_v = W'($urandom);
            rb_v = W'($urandom);
            case ($urandom_range(0, 7))
                0: ra_v = '0;
                1: rb_v = '0;
                2: ra_v = W'(1) << $urandom_range(0, W - 1);
                3: begin
                    ra_v = ra_v << $urandom_range(0, 4);
                    rb_v = rb_v << $urandom_range(0, 4);
                end
                default: ;
            endcase
            run_gcd("rand", ra_v, rb_v, lat, res);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
